// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the LSU.
// LSU has priority, fetch is protected by a streak limit, one transaction in flight.
module mem_arbiter #(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_lsu_req,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_we,
  input  logic [31:0] i_lsu_wdata,
  input  logic [1:0]  i_lsu_size,
  output logic        o_lsu_gnt,
  output logic        o_lsu_rvalid,
  output logic [31:0] o_lsu_rdata,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_size,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_LSU    = 1'b1;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);
  localparam logic [1:0] SIZE_WORD  = 2'd2;

  state_t      state;
  state_t      state_next;
  logic        owner;
  logic [3:0]  streak;
  logic        if_win;
  logic        lsu_win;
  logic        resp_fire;

  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;

  always_comb begin
    state_next = state;
    if_win     = 1'b0;
    lsu_win    = 1'b0;
    resp_fire  = 1'b0;
    case (state)
      IDLE: begin
        // Fetch only overtakes a competing LSU request once the streak is exhausted.
        if (i_lsu_req && (!i_if_req || (streak != STREAK_MAX))) begin
          lsu_win = 1'b1;
        end else if (i_if_req) begin
          if_win = 1'b1;
        end
        if (lsu_win || if_win) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (i_mem_gnt) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (i_mem_rvalid) begin
          resp_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      owner  <= OWN_IF;
      streak <= 4'd0;
    end else begin
      state <= state_next;
      if (lsu_win) begin
        owner <= OWN_LSU;
        if (!i_if_req) begin
          streak <= 4'd0;
        end else if (streak < STREAK_MAX) begin
          streak <= streak + 4'd1;
        end
      end else if (if_win) begin
        owner  <= OWN_IF;
        streak <= 4'd0;
      end
    end
  end

  // Request capture: the memory bus only changes when a new grant is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      size_q  <= SIZE_WORD;
    end else if (lsu_win) begin
      addr_q  <= i_lsu_addr;
      we_q    <= i_lsu_we;
      wdata_q <= i_lsu_wdata;
      size_q  <= i_lsu_size;
    end else if (if_win) begin
      addr_q  <= i_if_addr;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      size_q  <= SIZE_WORD;
    end
  end

  // Reset suppresses handshakes in the same cycle so a dropped response never leaks out.
  assign o_if_gnt     = if_win  && !i_rst;
  assign o_lsu_gnt    = lsu_win && !i_rst;
  assign o_if_rvalid  = resp_fire && (owner == OWN_IF)  && !i_rst;
  assign o_lsu_rvalid = resp_fire && (owner == OWN_LSU) && !i_rst;
  assign o_if_rdata   = o_if_rvalid  ? i_mem_rdata : 32'd0;
  assign o_lsu_rdata  = o_lsu_rvalid ? i_mem_rdata : 32'd0;

  assign o_mem_req   = (state == REQ);
  assign o_mem_addr  = addr_q;
  assign o_mem_we    = we_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_size  = size_q;
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single transactions plus
// hand-written sequences for stalls, streak arbitration and reset mid-response.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        lsu_req;
  logic [31:0] lsu_addr;
  logic        lsu_we;
  logic [31:0] lsu_wdata;
  logic [1:0]  lsu_size;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_LSU_STREAK(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .o_if_gnt     (if_gnt),
    .o_if_rvalid  (if_rvalid),
    .o_if_rdata   (if_rdata),
    .i_lsu_req    (lsu_req),
    .i_lsu_addr   (lsu_addr),
    .i_lsu_we     (lsu_we),
    .i_lsu_wdata  (lsu_wdata),
    .i_lsu_size   (lsu_size),
    .o_lsu_gnt    (lsu_gnt),
    .o_lsu_rvalid (lsu_rvalid),
    .o_lsu_rdata  (lsu_rdata),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .o_mem_size   (mem_size),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_busy       (busy)
  );

  // ctl = {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, mem_req, busy}
  logic [5:0]  act_ctl;
  logic [63:0] act_rd;
  logic [66:0] act_bus;
  assign act_ctl = {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, mem_req, busy};
  assign act_rd  = {if_rdata, lsu_rdata};
  assign act_bus = {mem_addr, mem_we, mem_wdata, mem_size};

  typedef struct {
    string       name;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsu_req;
    logic [31:0] lsu_addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        mg;
    logic        mr;
    logic [31:0] md;
    logic [5:0]  e_ctl;
    logic [31:0] e_if_rd;
    logic [31:0] e_lsu_rd;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [1:0]  e_size;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic r, logic ifr, logic [31:0] ifa,
                              logic lr, logic [31:0] la, logic we, logic [31:0] wd,
                              logic [1:0] sz, logic mg, logic mr, logic [31:0] md,
                              logic [5:0] ec, logic [31:0] eir, logic [31:0] elr,
                              logic [31:0] ea, logic ewe, logic [31:0] ewd, logic [1:0] esz);
    vec_t v;
    v.name = nm; v.rst = r; v.if_req = ifr; v.if_addr = ifa;
    v.lsu_req = lr; v.lsu_addr = la; v.we = we; v.wdata = wd; v.size = sz;
    v.mg = mg; v.mr = mr; v.md = md;
    v.e_ctl = ec; v.e_if_rd = eir; v.e_lsu_rd = elr;
    v.e_addr = ea; v.e_we = ewe; v.e_wdata = ewd; v.e_size = esz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    lsu_req = 1'b0; lsu_addr = 32'd0; lsu_we = 1'b0; lsu_wdata = 32'd0; lsu_size = 2'd2;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_order[11];
    int n;
    int cyc;

    set_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    //              name          rst ifr ifa        lr la         we wd            sz  mg mr md            ctl        eir           elr           addr       we wdata         sz
    vecs.push_back(mk("reset_idle",  0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 0, 32'h0,        6'b000000, 32'h0,        32'h0,        32'h0,     0, 32'h0,        2));
    vecs.push_back(mk("if_gnt",      0, 1, 32'h100,   0, 32'h0,     0, 32'h0,        2, 0, 0, 32'h0,        6'b100000, 32'h0,        32'h0,        32'h0,     0, 32'h0,        2));
    vecs.push_back(mk("if_memreq",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 1, 0, 32'h0,        6'b000011, 32'h0,        32'h0,        32'h100,   0, 32'h0,        2));
    vecs.push_back(mk("if_rvalid",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 1, 32'hDEADBEEF, 6'b001001, 32'hDEADBEEF, 32'h0,        32'h100,   0, 32'h0,        2));
    vecs.push_back(mk("if_done",     0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 0, 32'h0,        6'b000000, 32'h0,        32'h0,        32'h100,   0, 32'h0,        2));
    vecs.push_back(mk("st_gnt",      0, 0, 32'h0,     1, 32'h2000,  1, 32'h12345678, 0, 0, 0, 32'h0,        6'b010000, 32'h0,        32'h0,        32'h100,   0, 32'h0,        2));
    vecs.push_back(mk("st_stall",    0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 0, 32'h0,        6'b000011, 32'h0,        32'h0,        32'h2000,  1, 32'h12345678, 0));
    vecs.push_back(mk("st_memgnt",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 1, 0, 32'h0,        6'b000011, 32'h0,        32'h0,        32'h2000,  1, 32'h12345678, 0));
    vecs.push_back(mk("st_wait",     0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 0, 32'h0,        6'b000001, 32'h0,        32'h0,        32'h2000,  1, 32'h12345678, 0));
    vecs.push_back(mk("st_rvalid",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 1, 32'hCAFEF00D, 6'b000101, 32'h0,        32'hCAFEF00D, 32'h2000,  1, 32'h12345678, 0));
    vecs.push_back(mk("spur_idle",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 1, 32'h55,       6'b000000, 32'h0,        32'h0,        32'h2000,  1, 32'h12345678, 0));
    vecs.push_back(mk("if2_gnt",     0, 1, 32'h300,   0, 32'h0,     0, 32'h0,        2, 0, 0, 32'h0,        6'b100000, 32'h0,        32'h0,        32'h2000,  1, 32'h12345678, 0));
    vecs.push_back(mk("spur_req",    0, 0, 32'h0,     1, 32'h4000,  0, 32'h0,        2, 0, 1, 32'h66,       6'b000011, 32'h0,        32'h0,        32'h300,   0, 32'h0,        2));
    vecs.push_back(mk("busy_memgnt", 0, 0, 32'h0,     1, 32'h4000,  0, 32'h0,        2, 1, 0, 32'h0,        6'b000011, 32'h0,        32'h0,        32'h300,   0, 32'h0,        2));
    vecs.push_back(mk("busy_wait",   0, 0, 32'h0,     1, 32'h4000,  0, 32'h0,        2, 0, 0, 32'h0,        6'b000001, 32'h0,        32'h0,        32'h300,   0, 32'h0,        2));
    vecs.push_back(mk("if2_rvalid",  0, 0, 32'h0,     1, 32'h4000,  0, 32'h0,        2, 0, 1, 32'h11112222, 6'b001001, 32'h11112222, 32'h0,        32'h300,   0, 32'h0,        2));
    vecs.push_back(mk("ld_gnt",      0, 0, 32'h0,     1, 32'h4000,  0, 32'h0,        2, 0, 0, 32'h0,        6'b010000, 32'h0,        32'h0,        32'h300,   0, 32'h0,        2));
    vecs.push_back(mk("ld_memgnt",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 1, 0, 32'h0,        6'b000011, 32'h0,        32'h0,        32'h4000,  0, 32'h0,        2));
    vecs.push_back(mk("ld_rvalid",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 1, 32'h0BADF00D, 6'b000101, 32'h0,        32'h0BADF00D, 32'h4000,  0, 32'h0,        2));
    vecs.push_back(mk("ld_done",     0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        2, 0, 0, 32'h0,        6'b000000, 32'h0,        32'h0,        32'h4000,  0, 32'h0,        2));

    foreach (vecs[i]) begin
      step();
      rst = vecs[i].rst; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      lsu_req = vecs[i].lsu_req; lsu_addr = vecs[i].lsu_addr; lsu_we = vecs[i].we;
      lsu_wdata = vecs[i].wdata; lsu_size = vecs[i].size;
      mem_gnt = vecs[i].mg; mem_rvalid = vecs[i].mr; mem_rdata = vecs[i].md;
      #1;
      chk({vecs[i].name, "_ctl"}, act_ctl, vecs[i].e_ctl);
      chk({vecs[i].name, "_rdata"}, act_rd, {vecs[i].e_if_rd, vecs[i].e_lsu_rd});
      chk({vecs[i].name, "_bus"}, act_bus,
          {vecs[i].e_addr, vecs[i].e_we, vecs[i].e_wdata, vecs[i].e_size});
    end

    // Memory stall: grant held off 5 cycles, response delayed 3; IF waits throughout.
    step(); set_idle();
    lsu_req = 1'b1; lsu_addr = 32'hA0; lsu_we = 1'b1; lsu_wdata = 32'hA5A5A5A5; lsu_size = 2'd1;
    if_req = 1'b1; if_addr = 32'h900;
    #1 chk("stall_gnt", act_ctl, 6'b010000);
    for (int k = 0; k < 5; k++) begin
      step(); lsu_req = 1'b0; mem_gnt = 1'b0;
      #1 chk("stall_req_ctl", act_ctl, 6'b000011);
      chk("stall_req_bus", act_bus, {32'hA0, 1'b1, 32'hA5A5A5A5, 2'd1});
    end
    step(); mem_gnt = 1'b1;
    #1 chk("stall_memgnt", act_ctl, 6'b000011);
    for (int k = 0; k < 3; k++) begin
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1 chk("stall_resp_ctl", act_ctl, 6'b000001);
      chk("stall_resp_bus", act_bus, {32'hA0, 1'b1, 32'hA5A5A5A5, 2'd1});
    end
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h3C3C;
    #1 chk("stall_rvalid_ctl", act_ctl, 6'b000101);
    chk("stall_rvalid_rd", act_rd, {32'h0, 32'h3C3C});
    step(); mem_rvalid = 1'b0;
    #1 chk("wait_if_gnt", act_ctl, 6'b100000);
    step(); if_req = 1'b0; mem_gnt = 1'b1;
    #1 chk("wait_if_bus", act_bus, {32'h900, 1'b0, 32'h0, 2'd2});
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
    #1 chk("wait_if_rd", act_rd, {32'h99, 32'h0});

    // Both requesters held high with an always-ready memory: LSU x4, then IF.
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                  2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    step(); set_idle();
    if_req = 1'b1; if_addr = 32'h1000; lsu_req = 1'b1; lsu_addr = 32'h5000;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    n = 0;
    cyc = 0;
    while (n < 11 && cyc < 60) begin
      if (cyc != 0) step();
      #1;
      if (if_gnt || lsu_gnt) begin
        chk($sformatf("streak_gnt%0d", n), {if_gnt, lsu_gnt}, exp_order[n]);
        n++;
      end
      cyc++;
    end
    chk("streak_count", n, 11);
    step(); if_req = 1'b0; lsu_req = 1'b0;
    step();

    // Reset during RESP drops the response and returns everything to reset values.
    step(); set_idle(); if_req = 1'b1; if_addr = 32'h700;
    #1 chk("rst_if_gnt", act_ctl, 6'b100000);
    step(); if_req = 1'b0; mem_gnt = 1'b1;
    #1 chk("rst_memreq", act_ctl, 6'b000011);
    step(); mem_gnt = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1 chk("rst_in_resp_ctl", act_ctl, 6'b000001);
    chk("rst_in_resp_rd", act_rd, 64'h0);
    step(); rst = 1'b0; mem_rvalid = 1'b0;
    #1 chk("rst_after_ctl", act_ctl, 6'b000000);
    chk("rst_after_bus", act_bus, {32'h0, 1'b0, 32'h0, 2'd2});
    step(); lsu_req = 1'b1; lsu_addr = 32'h800;
    #1 chk("post_rst_gnt", act_ctl, 6'b010000);
    step(); lsu_req = 1'b0; mem_gnt = 1'b1;
    #1 chk("post_rst_bus", act_bus, {32'h800, 1'b0, 32'h0, 2'd2});
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h88;
    #1 chk("post_rst_rvalid", act_ctl, 6'b000101);
    chk("post_rst_rd", act_rd, {32'h0, 32'h88});
    step(); set_idle();
    #1 chk("final_idle", act_ctl, 6'b000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between instruction fetch (IF) and the load/store unit (LSU). It sits between the two requesters and the memory bus. It arbitrates with LSU priority plus an anti-starvation limit for fetch, and it keeps exactly one transaction outstanding. It captures each granted request into registers, drives it onto the memory port, and routes the response back to the requester that issued it.

## Interface
Parameters:
- MAX_LSU_STREAK, 4, max consecutive LSU grants while IF is waiting; range 1..15.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_if_req  input  1  fetch request; must stay high, with i_if_addr stable, until o_if_gnt.
- i_if_addr  input  32  fetch address.
- o_if_gnt  output  1  fetch request accepted this cycle.
- o_if_rvalid  output  1  fetch data valid; one-cycle pulse.
- o_if_rdata  output  32  fetch data; meaningful only while o_if_rvalid=1.
- i_lsu_req  input  1  LSU request; same hold rule as IF.
- i_lsu_addr  input  32  LSU address.
- i_lsu_we  input  1  1 = store, 0 = load.
- i_lsu_wdata  input  32  store data.
- i_lsu_size  input  2  access size (0 = byte, 1 = half, 2 = word).
- o_lsu_gnt  output  1  LSU request accepted this cycle.
- o_lsu_rvalid  output  1  LSU response; pulses for both loads and stores.
- o_lsu_rdata  output  32  load data.
- o_mem_req  output  1  memory request valid.
- o_mem_addr  output  32  registered address.
- o_mem_we  output  1  registered write enable (0 for fetch).
- o_mem_wdata  output  32  registered store data (0 for fetch).
- o_mem_size  output  2  registered size (2 for fetch).
- i_mem_gnt  input  1  memory accepted o_mem_req.
- i_mem_rvalid  input  1  memory response valid (reads and writes).
- i_mem_rdata  input  32  memory read data.
- o_busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, REQ, RESP. An owner register (IF or LSU) records which requester holds the port.
- IDLE, arbitration:
  - Only LSU requesting: LSU wins.
  - Only IF requesting: IF wins.
  - Both requesting: LSU wins unless streak == MAX_LSU_STREAK; then IF wins.
  - Winner's o_*_gnt = 1 (combinational). Address, we, wdata and size are latched and the owner is set. Next state is REQ.
- REQ: o_mem_req = 1. When i_mem_gnt = 1, go to RESP.
- RESP: o_mem_req = 0. When i_mem_rvalid = 1:
  - Owner's o_*_rvalid = 1 and o_*_rdata = i_mem_rdata (combinational pass-through).
  - Next state is IDLE.
- i_mem_rvalid outside RESP is ignored.
- o_*_gnt and o_*_rvalid are never asserted outside IDLE and RESP respectively. Both requesters are never granted in the same cycle.
- Streak counter, width 4, saturating at MAX_LSU_STREAK:
  - LSU grant with i_if_req = 1: increment.
  - LSU grant with i_if_req = 0: clear.
  - IF grant: clear.
- Unselected rdata outputs are driven to 0.

## Timing
- Reset values: state IDLE, streak 0, owner IF, o_mem_req 0, o_mem_addr/wdata 0, o_mem_we 0, o_mem_size 2, all gnt/rvalid 0, o_busy 0.
- Grant happens in the same cycle as the request when in IDLE. o_mem_req rises on the next cycle.
- Minimum latency: request at cycle N, i_mem_gnt at N+1, rvalid at N+2.
- Peak throughput is 1 transaction per 3 cycles. A new grant is possible in the cycle after the rvalid cycle.
- Memory stalls (i_mem_gnt = 0 or i_mem_rvalid = 0) hold the current state indefinitely. o_mem_* stay stable while o_mem_req = 1.
- A request arriving while busy waits; it is never granted mid-transaction.
- Reset mid-transaction: return to IDLE on the next edge. The pending response is dropped and no rvalid is issued. The memory must be reset in the same cycle.
- MAX_LSU_STREAK = 1 gives alternation when both requesters are continuously requesting.

## Test plan
- Single fetch: i_if_req with addr 0x100; memory grants at once and returns 0xDEADBEEF one cycle later. Required: o_if_gnt at N, o_mem_req at N+1, o_if_rvalid with 0xDEADBEEF at N+2, o_lsu_rvalid never asserted.
- Store: LSU we = 1, addr 0x2000, wdata 0x12345678, size 0. Required: o_mem_we = 1, o_mem_size = 0, o_mem_wdata = 0x12345678; o_lsu_rvalid pulses once.
- Both requesters held high continuously, MAX = 4. Required grant order: LSU, LSU, LSU, LSU, IF, LSU, ...
- Memory stall: i_mem_gnt held low for 5 cycles, then i_mem_rvalid delayed 3 cycles. Required: o_mem_* stable throughout, o_busy high, no new grant until rvalid.
- Spurious i_mem_rvalid in IDLE and in REQ: required no o_*_rvalid pulse and no state change.
- i_rst asserted during RESP: required state IDLE, all outputs at reset values next cycle, no rvalid, and a fresh request granted normally afterwards.
